// File: rtl/branch_redirect_controller.sv
// branch_redirect_controller
//   Sequences control-flow resolution between EX, the instruction cache and
//   fetch/decode. An accepted branch/jump/FENCE.I is latched, an I-cache flush
//   is run for FENCE.I, a redirect is offered to fetch until accepted, and a
//   one-cycle branch_reset releases decode from its branch-wait stall.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   IDLE       | waiting for a resolved control-flow instruction from EX
//   FLUSH_WAIT | FENCE.I accepted, I-cache invalidate requested
//   REDIRECT   | redirect_pc offered to fetch until fetch_ready
//   RELEASE    | one-cycle branch_reset pulse, then back to IDLE
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   stall_in                   MEM stall, blocks acceptance in IDLE only
//   ex_branch_valid/taken      resolved control-flow instruction from EX
//   ex_is_fencei               instruction is FENCE.I (implies taken)
//   ex_branch_target           resolved target (PC+4 for FENCE.I)
//   icache_flush_req/done      I-cache invalidate handshake
//   redirect_valid/pc          redirect offer to fetch
//   fetch_ready                fetch accepts the redirect
//   branch_reset               one-cycle release pulse
//   busy                       FSM not IDLE
//   redirect_count             completed redirects (wraps)
//   not_taken_count            resolved not-taken branches (wraps)
//   protocol_error             sticky protocol violation flag
module branch_redirect_controller #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_in,
  input  logic             ex_branch_valid,
  input  logic             ex_branch_taken,
  input  logic             ex_is_fencei,
  input  logic [XLEN-1:0]  ex_branch_target,
  output logic             icache_flush_req,
  input  logic             icache_flush_done,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  input  logic             fetch_ready,
  output logic             branch_reset,
  output logic             busy,
  output logic [CNT_W-1:0] redirect_count,
  output logic [CNT_W-1:0] not_taken_count,
  output logic             protocol_error
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FLUSH_WAIT = 2'd1,
    REDIRECT   = 2'd2,
    RELEASE    = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] PC_ALIGN_MASK = ~{{(XLEN-1){1'b0}}, 1'b1};

  state_t state, state_nxt;

  logic accept;
  logic fetch_take;
  logic violation;

  assign accept     = ex_branch_valid && !stall_in && (state == IDLE);
  assign fetch_take = (state == REDIRECT) && fetch_ready;
  // fetch_ready is only legal while a redirect is being offered.
  assign violation  = (ex_branch_valid && (state != IDLE)) ||
                      (fetch_ready && (state != REDIRECT));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (ex_is_fencei) begin
            state_nxt = FLUSH_WAIT;
          end else if (ex_branch_taken) begin
            state_nxt = REDIRECT;
          end else begin
            state_nxt = RELEASE;
          end
        end
      end
      FLUSH_WAIT: begin
        if (icache_flush_done) begin
          state_nxt = REDIRECT;
        end
      end
      REDIRECT: begin
        if (fetch_ready) begin
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Moore outputs
  always_comb begin
    icache_flush_req = 1'b0;
    redirect_valid   = 1'b0;
    branch_reset     = 1'b0;
    busy             = 1'b1;
    case (state)
      IDLE:       busy             = 1'b0;
      FLUSH_WAIT: icache_flush_req = 1'b1;
      REDIRECT:   redirect_valid   = 1'b1;
      RELEASE:    branch_reset     = 1'b1;
      default:    busy             = 1'b1;
    endcase
  end

  // Redirect target, halfword aligned; only an accept may change it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_pc <= '0;
    end else if (accept) begin
      redirect_pc <= ex_branch_target & PC_ALIGN_MASK;
    end
  end

  // Statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_count  <= '0;
      not_taken_count <= '0;
    end else begin
      if (fetch_take) begin
        redirect_count <= redirect_count + 1'b1;
      end
      if (accept && !ex_is_fencei && !ex_branch_taken) begin
        not_taken_count <= not_taken_count + 1'b1;
      end
    end
  end

  // Sticky protocol violation flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      protocol_error <= 1'b0;
    end else if (violation) begin
      protocol_error <= 1'b1;
    end
  end

endmodule

// File: doc/branch_redirect_controller.md
# branch_redirect_controller

Sequences control-flow resolution between EX, the instruction cache and fetch/decode. When EX resolves a branch, jump or FENCE.I, the block latches the outcome and runs any required instruction-cache flush. It holds a redirect to fetch until fetch accepts it, then issues the one-cycle `branch_reset` that releases decode from its branch-wait stall. It also keeps redirect statistics and flags protocol violations for verification.

## Interface
- `XLEN`, 64, address/data width
- `CNT_W`, 32, width of statistics counters
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `stall_in`  in  1  downstream (MEM) stall; EX is frozen while high
- `ex_branch_valid`  in  1  EX presents a resolved control-flow instruction this cycle
- `ex_branch_taken`  in  1  redirect required (JAL/JALR/taken branch/FENCE.I)
- `ex_is_fencei`  in  1  instruction is FENCE.I
- `ex_branch_target`  in  XLEN  resolved target (PC+4 for FENCE.I)
- `icache_flush_req`  out  1  request instruction-cache invalidate
- `icache_flush_done`  in  1  one-cycle flush-complete pulse
- `redirect_valid`  out  1  redirect offer to fetch
- `redirect_pc`  out  XLEN  redirect address, bit 0 forced to 0
- `fetch_ready`  in  1  fetch accepts redirect this cycle
- `branch_reset`  out  1  one-cycle release pulse to decode/fetch
- `busy`  out  1  state ≠ IDLE
- `redirect_count`  out  CNT_W  completed redirects
- `not_taken_count`  out  CNT_W  resolved not-taken branches
- `protocol_error`  out  1  sticky violation flag

## Operation
- States: IDLE, FLUSH_WAIT, REDIRECT, RELEASE.
- Accept condition: `ex_branch_valid && !stall_in && state==IDLE`. While `stall_in` is high, nothing is accepted and the state does not advance from IDLE.
- On accept, the block latches `{ex_branch_target[XLEN-1:1],1'b0}` into `redirect_pc`. Next state:
  - `ex_is_fencei` → FLUSH_WAIT. `ex_is_fencei` implies taken; taken is ignored.
  - `ex_branch_taken` → REDIRECT.
  - not taken → RELEASE; `not_taken_count` increments.
- FLUSH_WAIT:
  - `icache_flush_req`=1 throughout.
  - On `icache_flush_done` → REDIRECT.
  - `icache_flush_done` outside FLUSH_WAIT is ignored.
- REDIRECT:
  - `redirect_valid`=1 and `redirect_pc` is held stable.
  - On `fetch_ready` → RELEASE; `redirect_count` increments.
- RELEASE: `branch_reset`=1 for exactly this cycle, then → IDLE unconditionally.
- `stall_in` affects IDLE acceptance only. FLUSH_WAIT, REDIRECT and RELEASE advance regardless of it.
- `protocol_error` is set and held until reset on either of:
  - `ex_branch_valid` while state≠IDLE;
  - `fetch_ready` while `redirect_valid`=0.
  
  The offending input has no other effect.
- Counters are CNT_W unsigned and wrap modulo 2^CNT_W.
- `redirect_valid`, `icache_flush_req`, `branch_reset` and `busy` are Moore outputs decoded from state.

## Timing
- Reset (async assert, synchronous release via the flop path): state=IDLE. All outputs are 0, including `redirect_pc`, both counters and `protocol_error`. Reset mid-operation aborts immediately: `icache_flush_req`, `redirect_valid` and `branch_reset` drop without waiting for a clock.
- In each latency below, cycle A is the accept cycle.
- Not-taken branch: `branch_reset` in cycle A+1; `busy` high in A+1 only.
- Taken branch with `fetch_ready`=1 constantly: `redirect_valid` in A+1, `branch_reset` in A+2, IDLE in A+3.
- Taken branch with `fetch_ready` delayed: `redirect_valid` holds until the first cycle R where `fetch_ready`=1. `branch_reset` follows in R+1.
- FENCE.I: `icache_flush_req` from A+1 through the cycle F where `icache_flush_done`=1. `redirect_valid` starts in F+1. If `icache_flush_done` arrives in A+1, `redirect_valid` starts in A+2.
- Back-to-back: a new accept is possible in the cycle the FSM is IDLE after RELEASE. Minimum spacing between accepts is 2 cycles for not-taken and 3 for taken.
- `branch_reset` is never asserted in two consecutive cycles.

## Test plan
- Reset: drive `rst_n`=0 mid-REDIRECT with `redirect_pc`=0x8000_0010 → `redirect_valid` drops the same cycle; after release, all outputs are 0 and `busy`=0.
- Taken JALR: target 0x0000_0000_0000_1003, `fetch_ready`=1 → `redirect_pc`=0x…1002 in A+1, `branch_reset` pulse in A+2, `redirect_count`=1.
- Not-taken branch, then a taken branch in the cycle after RELEASE → first gives `branch_reset` in A+1 and `not_taken_count`=1; second is accepted, `redirect_count`=1.
- Fetch backpressure: `fetch_ready` low for 5 cycles, target 0x400 → `redirect_valid` high for 6 cycles with `redirect_pc` stable at 0x400, then one `branch_reset`.
- FENCE.I: target 0x204, `icache_flush_done` pulse 7 cycles after accept → `icache_flush_req` high 7 cycles, redirect to 0x204, `branch_reset`, and `protocol_error`=0.
- Violations: `ex_branch_valid` during FLUSH_WAIT, and `ex_branch_valid` with `stall_in`=1 in IDLE → first sets `protocol_error` with the state unchanged; second is not accepted and sets no error.
